// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Holds the state encoding, requester count, hold-counter width and winner search.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // First set request at or above ptr, wrapping; the lowest offset is applied last so it wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] idx;
        rr_pick = p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = p + IDX_W'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/arb4_rr_if.sv
// Request/grant bundle between requesters and the arbiter, plus the FSM state for observation.
// Protocol: a requester holds req[i] until it is done; gnt/gnt_idx are valid only while gnt_valid=1.
interface arb4_rr_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout;
    state_t             state;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout, state
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout, state
    );

endinterface

// File: rtl/dec2to4.sv
// Binary-to-one-hot decoder used to build the grant vector from the owner index.
module dec2to4 (
    input  logic [1:0] idx,
    output logic [3:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with per-grant hold limit and a one-cycle gap between owners.
// All outputs are registered; next values are computed in a single combinational block.
module arb4_rr
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    arb4_rr_if.slave   bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               timeout_nx;
    logic               hold_hit;
    logic               owner_req;
    logic               release_now;
    logic [NUM_REQ-1:0] gnt_dec;

    assign hold_hit    = (cnt == HOLD_LAST);
    assign owner_req   = bus.req[idx];
    assign release_now = bus.done || !owner_req || hold_hit;

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        idx_nx     = idx;
        cnt_nx     = cnt;
        timeout_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_nx = ST_BUSY;
                    idx_nx   = rr_pick(bus.req, ptr);
                    cnt_nx   = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_nx   = ST_GAP;
                    ptr_nx     = idx + IDX_W'(1);
                    cnt_nx     = '0;
                    // Only a pure hold-limit release is reported; done or a dropped request wins.
                    timeout_nx = hold_hit && !bus.done && owner_req;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_GAP:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    dec2to4 u_dec (
        .idx    (idx_nx),
        .onehot (gnt_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            idx           <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.gnt_idx   <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            state         <= state_nx;
            ptr           <= ptr_nx;
            idx           <= idx_nx;
            cnt           <= cnt_nx;
            bus.gnt       <= (state_nx == ST_BUSY) ? gnt_dec : '0;
            bus.gnt_idx   <= idx_nx;
            bus.gnt_valid <= (state_nx == ST_BUSY);
            bus.timeout   <= timeout_nx;
        end
    end

    assign bus.state = state;

endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr: directed scenarios on a MAX_HOLD=15 and a MAX_HOLD=1 instance,
// then randomized traffic on both checked against a behavioural model.
module tb_arb4_rr;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arb4_rr_if bus_a ();
    arb4_rr_if bus_b ();

    arb4_rr #(.MAX_HOLD(15)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    arb4_rr #(.MAX_HOLD(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: owner is -1 when nobody holds the resource
    int owner [2];
    int held  [2];
    int rr_ptr[2];
    bit in_gap[2];
    bit exp_to[2];

    logic [3:0] exp_q[$];

    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.req = '0; bus_a.done = 1'b0;
        bus_b.req = '0; bus_b.done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            owner[u] = -1; held[u] = 0; rr_ptr[u] = 0; in_gap[u] = 0; exp_to[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input logic [3:0] r, input logic d, input int max_hold);
        int cycles;
        bit found;
        exp_to[u] = 0;
        if (owner[u] >= 0) begin
            cycles = held[u] + 1;
            if (d || !r[owner[u]] || cycles >= max_hold) begin
                exp_to[u] = !d && r[owner[u]];
                rr_ptr[u] = (owner[u] + 1) % 4;
                owner[u]  = -1;
                in_gap[u] = 1;
            end else begin
                held[u] = cycles;
            end
        end else if (in_gap[u]) begin
            in_gap[u] = 0;
        end else if (r != 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(rr_ptr[u] + k) % 4]) begin
                    owner[u] = (rr_ptr[u] + k) % 4;
                    found = 1;
                end
            end
            held[u] = 0;
        end
    endtask

    task automatic wait_grant(input string name, output bit ok);
        int w = 0;
        while (!bus_a.gnt_valid && w < 8) begin step(); w++; end
        ok = bus_a.gnt_valid;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s_wait: got gnt_valid=0 expected 1 within 8 cycles", name); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.req = '0; bus_a.done = 1'b0;
        bus_b.req = '0; bus_b.done = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus_a.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", bus_a.gnt); end
        n_checks++; if (bus_a.gnt_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus_a.gnt_idx); end
        n_checks++; if (bus_a.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus_a.gnt_valid); end
        n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", bus_a.timeout); end
        n_checks++; if (bus_a.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus_a.state, ST_IDLE); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        bus_a.req = 4'b0100;
        step();
        n_checks++; if (bus_a.gnt !== 4'b0100) begin n_fail++; $display("FAIL basic_gnt: got %b expected 0100", bus_a.gnt); end
        n_checks++; if (bus_a.gnt_idx !== 2'd2) begin n_fail++; $display("FAIL basic_idx: got %0d expected 2", bus_a.gnt_idx); end
        step(); step();
        n_checks++; if (bus_a.gnt !== 4'b0100) begin n_fail++; $display("FAIL basic_hold: got %b expected 0100", bus_a.gnt); end
        bus_a.done = 1'b1;
        step();
        bus_a.done = 1'b0;
        n_checks++; if (bus_a.gnt !== 4'b0000) begin n_fail++; $display("FAIL basic_release: got %b expected 0000", bus_a.gnt); end
        n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("FAIL basic_no_timeout: got %b expected 0", bus_a.timeout); end
        bus_a.req = 4'b1111;
        step();
        n_checks++; if (bus_a.gnt !== 4'b0000) begin n_fail++; $display("FAIL basic_idle: got %b expected 0000", bus_a.gnt); end
        step();
        n_checks++; if (bus_a.gnt_idx !== 2'd3) begin n_fail++; $display("FAIL basic_ptr3: got %0d expected 3", bus_a.gnt_idx); end
        bus_a.req = '0;
    endtask

    task automatic test_rotation();
        bit ok;
        logic [3:0] exp_idx;
        do_reset();
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        bus_a.req = 4'b1111;
        while (exp_q.size() > 0) begin
            wait_grant("rotation", ok);
            if (!ok) break;
            exp_idx = exp_q.pop_front();
            n_checks++; if ({2'b00, bus_a.gnt_idx} !== exp_idx) begin n_fail++; $display("FAIL rotation_order: got %0d expected %0d", bus_a.gnt_idx, exp_idx); end
            step(); step();
            n_checks++; if (bus_a.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL rotation_hold: got %b expected 1", bus_a.gnt_valid); end
            bus_a.done = 1'b1;
            step();
            bus_a.done = 1'b0;
            n_checks++; if (bus_a.gnt !== 4'b0000) begin n_fail++; $display("FAIL rotation_gap: got %b expected 0000", bus_a.gnt); end
        end
        bus_a.req = '0;
    endtask

    task automatic test_timeout();
        bit ok;
        int count = 0;
        do_reset();
        bus_a.req = 4'b0010;
        wait_grant("timeout", ok);
        while (bus_a.gnt === 4'b0010 && count < 40) begin count++; step(); end
        n_checks++; if (count !== 15) begin n_fail++; $display("FAIL timeout_len: got %0d expected 15", count); end
        n_checks++; if (bus_a.timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 1", bus_a.timeout); end
        step();
        n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_width: got %b expected 0", bus_a.timeout); end
        step();
        n_checks++; if (bus_a.gnt !== 4'b0010) begin n_fail++; $display("FAIL timeout_regrant: got %b expected 0010", bus_a.gnt); end
        bus_a.req = '0;
    endtask

    task automatic test_req_drop();
        bit ok;
        do_reset();
        bus_a.req = 4'b0001;
        wait_grant("drop", ok);
        bus_a.done = 1'b1;
        step();
        bus_a.done = 1'b0;
        bus_a.req = 4'b1001;
        step(); step();
        n_checks++; if (bus_a.gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_first: got %b expected 1000", bus_a.gnt); end
        step();
        bus_a.req = 4'b0001;
        step();
        n_checks++; if (bus_a.gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_release: got %b expected 0000", bus_a.gnt); end
        n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("FAIL drop_no_timeout: got %b expected 0", bus_a.timeout); end
        step(); step();
        n_checks++; if (bus_a.gnt !== 4'b0001) begin n_fail++; $display("FAIL drop_next: got %b expected 0001", bus_a.gnt); end
        bus_a.req = '0;
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        bus_a.req = 4'b0100;
        wait_grant("areset", ok);
        step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus_a.gnt !== 4'b0000) begin n_fail++; $display("FAIL areset_gnt: got %b expected 0000", bus_a.gnt); end
        n_checks++; if (bus_a.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", bus_a.gnt_valid); end
        n_checks++; if (bus_a.timeout !== 1'b0) begin n_fail++; $display("FAIL areset_timeout: got %b expected 0", bus_a.timeout); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.req = 4'b1000;
        step();
        n_checks++; if (bus_a.gnt !== 4'b1000) begin n_fail++; $display("FAIL areset_regrant: got %b expected 1000", bus_a.gnt); end
        bus_a.req = 4'b1010;
        bus_a.done = 1'b1;
        step();
        bus_a.done = 1'b0;
        bus_a.req = '0;
    endtask

    task automatic test_max_hold1();
        do_reset();
        bus_b.req = 4'b0100;
        step();
        n_checks++; if (bus_b.gnt !== 4'b0100) begin n_fail++; $display("FAIL mh1_gnt: got %b expected 0100", bus_b.gnt); end
        step();
        n_checks++; if (bus_b.gnt !== 4'b0000) begin n_fail++; $display("FAIL mh1_len: got %b expected 0000", bus_b.gnt); end
        n_checks++; if (bus_b.timeout !== 1'b1) begin n_fail++; $display("FAIL mh1_timeout: got %b expected 1", bus_b.timeout); end
        step(); step();
        n_checks++; if (bus_b.gnt !== 4'b0100) begin n_fail++; $display("FAIL mh1_regrant: got %b expected 0100", bus_b.gnt); end
        bus_b.req = '0;
    endtask

    task automatic test_random();
        logic [3:0] g, one;
        logic [1:0] gi;
        logic gv, to;
        one = 4'b0001;
        do_reset();
        model_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) bus_a.req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus_b.req = 4'($urandom_range(0, 15));
            bus_a.done = ($urandom_range(0, 11) == 0);
            bus_b.done = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            model_step(0, bus_a.req, bus_a.done, 15);
            model_step(1, bus_b.req, bus_b.done, 1);
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                g  = (u == 0) ? bus_a.gnt       : bus_b.gnt;
                gi = (u == 0) ? bus_a.gnt_idx   : bus_b.gnt_idx;
                gv = (u == 0) ? bus_a.gnt_valid : bus_b.gnt_valid;
                to = (u == 0) ? bus_a.timeout   : bus_b.timeout;
                n_checks++; if (g !== ((owner[u] >= 0) ? (one << owner[u]) : 4'b0000)) begin n_fail++; $display("FAIL rand_gnt[%0d] cycle %0d: got %b expected owner %0d", u, n, g, owner[u]); end
                n_checks++; if (gv !== (owner[u] >= 0)) begin n_fail++; $display("FAIL rand_valid[%0d] cycle %0d: got %b expected %b", u, n, gv, owner[u] >= 0); end
                n_checks++; if (to !== exp_to[u]) begin n_fail++; $display("FAIL rand_timeout[%0d] cycle %0d: got %b expected %b", u, n, to, exp_to[u]); end
                n_checks++; if (!$onehot0(g)) begin n_fail++; $display("FAIL rand_onehot[%0d] cycle %0d: got %b expected one-hot or zero", u, n, g); end
                if (owner[u] >= 0) begin
                    n_checks++; if (int'(gi) !== owner[u]) begin n_fail++; $display("FAIL rand_idx[%0d] cycle %0d: got %0d expected %0d", u, n, gi, owner[u]); end
                    n_checks++; if (g !== (one << gi)) begin n_fail++; $display("FAIL rand_decode[%0d] cycle %0d: got %b expected decode of %0d", u, n, g, gi); end
                end
            end
        end
        bus_a.req = '0; bus_b.req = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_timeout();
        test_req_drop();
        test_async_reset();
        test_max_hold1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/arb4_rr.md
ARB4_RR -- requirements
Module: arb4_rr

Interface
REQ-001 Parameter MAX_HOLD, default 15, is the maximum number of cycles a grant is held before forced release; its legal range is 1..255.
REQ-002 clk  input  1  Single clock for the block; all state changes on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 req  input  4  Request lines; req[i] is requester i.
REQ-005 done  input  1  Shared resource signals that the current owner's transfer is complete.
REQ-006 gnt  output  4  One-hot grant; gnt[i] grants requester i.
REQ-007 gnt_idx  output  2  Binary index of the current owner; valid only while gnt_valid=1.
REQ-008 gnt_valid  output  1  High while any grant is active.
REQ-009 timeout  output  1  Single-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-010 The FSM SHALL have states IDLE, BUSY and GAP, encoded in 2 bits.
REQ-011 In IDLE with req==0, the FSM SHALL remain in IDLE with gnt=0.
REQ-012 In IDLE with req!=0 at edge k, the FSM SHALL enter BUSY, and gnt SHALL be valid after edge k (1-cycle latency from sampled request).
REQ-013 The winner SHALL be the first set req bit searched upward from pointer ptr (2 bits), wrapping 3->0.
REQ-014 gnt SHALL be the 2-to-4 decode of gnt_idx, exactly one bit set in BUSY and all zero otherwise; gnt_valid SHALL equal (state==BUSY).
REQ-015 gnt_idx SHALL hold constant for the whole BUSY interval; new requests SHALL NOT preempt.
REQ-016 A hold counter (8 bits) SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-017 BUSY SHALL exit to GAP on the first edge where done=1, req[gnt_idx]=0, or the counter equals MAX_HOLD-1, whichever occurs first.
REQ-018 timeout SHALL pulse for the one cycle following a release caused only by the counter; done or req drop on the same edge SHALL suppress timeout.
REQ-019 On every BUSY->GAP transition, ptr SHALL become gnt_idx+1 modulo 4.
REQ-020 GAP SHALL last exactly one cycle with gnt=0 and SHALL then return to IDLE.
REQ-021 done while not in BUSY SHALL be ignored.
REQ-022 With MAX_HOLD=1, every grant SHALL last exactly one cycle.

Reset
REQ-023 On rst_n=0, state SHALL become IDLE, and ptr, counter, gnt, gnt_idx, gnt_valid and timeout SHALL all become 0, asynchronously.
REQ-024 Reset asserted mid-BUSY SHALL drop gnt immediately without a timeout pulse; after deassertion, arbitration SHALL restart from ptr=0.

Structure
REQ-025 State encodings, NUM_REQ=4, and the counter width 8 SHALL live in a shared package arb_pkg.
REQ-026 The one-hot grant decode SHALL be a separate sub-module dec2to4 (input 2 bits, output 4 bits one-hot, out[i] high when in==i).
REQ-027 The block SHALL be about 150-250 lines of RTL with registered outputs only.

Verification
REQ-028 Reset, then req=4'b0100 at edge 1 -> gnt=4'b0100 and gnt_idx=2 after edge 1; done=1 at edge 4 -> gnt=0 after edge 4, and ptr=3.
REQ-029 req=4'b1111 held, done pulsed every 3rd BUSY cycle -> grant order 0,1,2,3,0, each grant separated by one GAP cycle.
REQ-030 MAX_HOLD=15, req=4'b0010 held with done=0 -> gnt=4'b0010 for exactly 15 cycles, then a timeout pulse of 1 cycle, then re-grant of 1 after GAP.
REQ-031 req=4'b1001 at ptr=1 -> grant 3 first; drop req[3] mid-BUSY -> release without timeout, then grant 0.
REQ-032 rst_n=0 asserted mid-BUSY asynchronously -> gnt=0 before the next clk edge; after release with req=4'b1000 -> grant 3, found from ptr=0.
REQ-033 Checker: gnt is one-hot or zero on every cycle, and gnt==dec(gnt_idx) whenever gnt_valid=1.
